// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single write port of the register bank between NUM_REQ
// writeback requesters. Each requester hands a write (select + data) into a
// private one-entry holding buffer over a valid/ready handshake. A
// round-robin arbiter picks one buffered write per cycle and drives the
// bank's write port from registered outputs.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   i_req_valid      bit i: requester i presents a write
//   i_req_select     slice i: target register of requester i
//   i_req_data       slice i: write data of requester i
//   o_req_ready      bit i: buffer i accepts this cycle
//   o_write_enable   bank write enable
//   o_write_select   bank write register select
//   o_write_data     bank write data
//   o_write_id       requester owning the current o_write_* beat
//   o_drop           one-cycle pulse: an out-of-range select was discarded
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter  int NUM_REQ      = 4,
    parameter  int DATA_WIDTH   = 32,
    parameter  int NUM_REG      = 32,
    localparam int SELECT_WIDTH = $clog2(NUM_REG),
    localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    input  logic [NUM_REQ*SELECT_WIDTH-1:0] i_req_select,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]              o_req_ready,
    output logic                            o_write_enable,
    output logic [SELECT_WIDTH-1:0]         o_write_select,
    output logic [DATA_WIDTH-1:0]           o_write_data,
    output logic [ID_WIDTH-1:0]             o_write_id,
    output logic                            o_drop
);

    // Holding buffers
    logic [NUM_REQ-1:0]      buf_valid_q, buf_valid_d;
    logic [SELECT_WIDTH-1:0] buf_sel_q  [NUM_REQ];
    logic [SELECT_WIDTH-1:0] buf_sel_d  [NUM_REQ];
    logic [DATA_WIDTH-1:0]   buf_data_q [NUM_REQ];
    logic [DATA_WIDTH-1:0]   buf_data_d [NUM_REQ];

    // Round-robin pointer
    logic [ID_WIDTH-1:0]     ptr_q, ptr_d;

    // Registered write port
    logic                    write_enable_q, write_enable_d;
    logic [SELECT_WIDTH-1:0] write_select_q, write_select_d;
    logic [DATA_WIDTH-1:0]   write_data_q,   write_data_d;
    logic [ID_WIDTH-1:0]     write_id_q,     write_id_d;
    logic                    drop_q,         drop_d;

    // Arbitration
    logic [NUM_REQ-1:0]      grant;
    logic                    grant_any;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic [SELECT_WIDTH-1:0] grant_sel;
    logic [DATA_WIDTH-1:0]   grant_data;

    // Handshake
    logic [NUM_REQ-1:0]      accept;
    logic [NUM_REQ-1:0]      in_range;

    // A select can only exceed the bank when NUM_REG is not a power of two;
    // otherwise every encodable select is a real register.
    generate
        if (NUM_REG == (1 << SELECT_WIDTH)) begin : g_all_in_range
            assign in_range = '1;
        end else begin : g_range_check
            for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
                assign in_range[gi] =
                    ({1'b0, i_req_select[gi*SELECT_WIDTH +: SELECT_WIDTH]}
                     < (SELECT_WIDTH+1)'(NUM_REG));
            end
        end
    endgenerate

    // Round-robin scan: first pass covers indices ptr..NUM_REQ-1, second
    // pass wraps around to 0..ptr-1. The first valid buffer found wins.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_sel  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && buf_valid_q[i] && (i >= int'(ptr_q))) begin
                grant_any  = 1'b1;
                grant[i]   = 1'b1;
                grant_idx  = ID_WIDTH'(i);
                grant_sel  = buf_sel_q[i];
                grant_data = buf_data_q[i];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && buf_valid_q[i] && (i < int'(ptr_q))) begin
                grant_any  = 1'b1;
                grant[i]   = 1'b1;
                grant_idx  = ID_WIDTH'(i);
                grant_sel  = buf_sel_q[i];
                grant_data = buf_data_q[i];
            end
        end
    end

    // A buffer being drained this cycle can be refilled at the same edge,
    // which keeps a single streaming requester at one write per cycle.
    assign o_req_ready = rst ? '0 : (~buf_valid_q | grant);
    assign accept      = i_req_valid & o_req_ready;

    always_comb begin
        buf_valid_d    = buf_valid_q;
        buf_sel_d      = buf_sel_q;
        buf_data_d     = buf_data_q;
        ptr_d          = ptr_q;
        write_enable_d = 1'b0;
        write_select_d = write_select_q;
        write_data_d   = write_data_q;
        write_id_d     = write_id_q;
        drop_d         = |(accept & ~in_range);

        for (int i = 0; i < NUM_REQ; i++) begin
            // Out-of-range writes complete the handshake but never occupy the
            // buffer; a granted buffer still drains in that case.
            if (accept[i] && in_range[i]) begin
                buf_valid_d[i] = 1'b1;
                buf_sel_d[i]   = i_req_select[i*SELECT_WIDTH +: SELECT_WIDTH];
                buf_data_d[i]  = i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else if (grant[i]) begin
                buf_valid_d[i] = 1'b0;
            end
        end

        if (grant_any) begin
            write_enable_d = 1'b1;
            write_select_d = grant_sel;
            write_data_d   = grant_data;
            write_id_d     = grant_idx;
            if (grant_idx == ID_WIDTH'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + ID_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q    <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_sel_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
            ptr_q          <= '0;
            write_enable_q <= 1'b0;
            write_select_q <= '0;
            write_data_q   <= '0;
            write_id_q     <= '0;
            drop_q         <= 1'b0;
        end else begin
            buf_valid_q    <= buf_valid_d;
            buf_sel_q      <= buf_sel_d;
            buf_data_q     <= buf_data_d;
            ptr_q          <= ptr_d;
            write_enable_q <= write_enable_d;
            write_select_q <= write_select_d;
            write_data_q   <= write_data_d;
            write_id_q     <= write_id_d;
            drop_q         <= drop_d;
        end
    end

    assign o_write_enable = write_enable_q;
    assign o_write_select = write_select_q;
    assign o_write_data   = write_data_q;
    assign o_write_id     = write_id_q;
    assign o_drop         = drop_q;

endmodule
